// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package boot_pkg;

  localparam int unsigned BOOT_ADDR_W = 14;

  localparam logic [3:0] WEB_NONE = 4'b1111;
  localparam logic [3:0] WEB_WORD = 4'b0000;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDrain,
    StDone
  } boot_state_e;

endpackage

// File: rtl/im_boot_loader_if.sv
// Source-SRAM read port and instruction-SRAM write port driven by the boot loader.
interface im_boot_loader_if
  import boot_pkg::*;
#(
  parameter int unsigned ADDR_W = BOOT_ADDR_W
);
  logic              src_oe;
  logic [ADDR_W-1:0] src_a;
  logic [31:0]       src_do;
  logic [3:0]        im_web;
  logic [ADDR_W-1:0] im_a;
  logic [31:0]       im_di;

  modport master (
    output src_oe, src_a, im_web, im_a, im_di,
    input  src_do
  );

  modport slave (
    input  src_oe, src_a, im_web, im_a, im_di,
    output src_do
  );
endinterface

// File: rtl/boot_csum.sv
// 32-bit image checksum: clear on start, add each written word, sticky compare at the end.
module boot_csum
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        add,
  input  logic [31:0] add_data,
  input  logic        check,
  input  logic [31:0] exp_sum,
  output logic [31:0] sum,
  output logic        err,
  output logic        mismatch
);

  logic [31:0] sum_q;
  logic        err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else if (clr) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (add) sum_q <= sum_q + add_data;
      if (check && mismatch) err_q <= 1'b1;
    end
  end

  assign mismatch = (sum_q != exp_sum);
  assign sum      = sum_q;
  assign err      = err_q;

endmodule

// File: rtl/im_boot_loader.sv
// Streams a boot image from the source SRAM into the instruction SRAM, then releases the CPU.
// Optional image checksum enabled by defining BOOT_CHECKSUM_EN.
module im_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned ADDR_W = BOOT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W:0]   len,
  input  logic [31:0]       exp_sum,
  im_boot_loader_if.master  mem,
  output logic              busy,
  output logic              done,
  output logic              cpu_hold,
  output logic [31:0]       csum,
  output logic              csum_err
);

  boot_state_e       state_q, state_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              src_oe_q, src_oe_d;
  logic [ADDR_W-1:0] src_a_q, src_a_d;
  logic [3:0]        web_q, web_d;
  logic [ADDR_W-1:0] im_a_q, im_a_d;
  logic [31:0]       im_di_q, im_di_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic              first_q, first_d;
  logic              busy_q, busy_d;
  logic              loaded_q, loaded_d;
  logic              csum_clr;
  logic              csum_bad;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      rem_q    <= '0;
      src_oe_q <= 1'b0;
      src_a_q  <= '0;
      web_q    <= WEB_NONE;
      im_a_q   <= '0;
      im_di_q  <= '0;
      dst_q    <= '0;
      first_q  <= 1'b0;
      busy_q   <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      src_oe_q <= src_oe_d;
      src_a_q  <= src_a_d;
      web_q    <= web_d;
      im_a_q   <= im_a_d;
      im_di_q  <= im_di_d;
      dst_q    <= dst_d;
      first_q  <= first_d;
      busy_q   <= busy_d;
      loaded_q <= loaded_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    src_oe_d = src_oe_q;
    src_a_d  = src_a_q;
    web_d    = WEB_NONE;
    im_a_d   = im_a_q;
    im_di_d  = im_di_q;
    dst_d    = dst_q;
    first_d  = first_q;
    busy_d   = busy_q;
    loaded_d = loaded_q;
    csum_clr = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          csum_clr = 1'b1;
          if (len != '0) begin
            state_d  = StStream;
            rem_d    = len;
            src_a_d  = src_base;
            src_oe_d = 1'b1;
            dst_d    = dst_base;
            first_d  = 1'b1;
            busy_d   = 1'b1;
          end else begin
            state_d = StDone;
          end
        end
      end
      StStream: begin
        // SRAM read data for the address issued last cycle is valid now.
        im_di_d = mem.src_do;
        im_a_d  = first_q ? dst_q : im_a_q + 1'b1;
        first_d = 1'b0;
        web_d   = WEB_WORD;
        src_a_d = src_a_q + 1'b1;
        rem_d   = rem_q - 1'b1;
        if (rem_q == {{ADDR_W{1'b0}}, 1'b1}) begin
          src_oe_d = 1'b0;
          state_d  = StDrain;
        end
      end
      StDrain: begin
        state_d = StDone;
      end
      StDone: begin
        busy_d   = 1'b0;
        loaded_d = ~csum_bad;
        state_d  = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

`ifdef BOOT_CHECKSUM_EN
  boot_csum u_csum (
    .clk      (clk),
    .rst      (rst),
    .clr      (csum_clr),
    .add      (web_q == WEB_WORD),
    .add_data (im_di_q),
    .check    (state_q == StDone),
    .exp_sum  (exp_sum),
    .sum      (csum),
    .err      (csum_err),
    .mismatch (csum_bad)
  );
`else
  logic unused_csum;
  assign unused_csum = ^{exp_sum, csum_clr};
  assign csum        = '0;
  assign csum_err    = 1'b0;
  assign csum_bad    = 1'b0;
`endif

  assign mem.src_oe = src_oe_q;
  assign mem.src_a  = src_a_q;
  assign mem.im_web = web_q;
  assign mem.im_a   = im_a_q;
  assign mem.im_di  = im_di_q;

  assign busy     = busy_q;
  assign done     = (state_q == StDone);
  assign cpu_hold = busy_q | ~loaded_q;

endmodule

// File: tb/tb_im_boot_loader.sv
// Scoreboard bench for im_boot_loader with behavioural source and instruction SRAMs.
module tb_im_boot_loader;

  localparam int unsigned AW = 14;
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [31:0] SENTINEL = 32'hDEAD_BEEF;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] src_base;
  logic [AW-1:0] dst_base;
  logic [AW:0]   len;
  logic [31:0]   exp_sum;
  logic          busy;
  logic          done;
  logic          cpu_hold;
  logic [31:0]   csum;
  logic          csum_err;

  logic [31:0] src_mem [DEPTH];
  logic [31:0] im_mem  [DEPTH];
  wr_t         sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_writes = 0;

  im_boot_loader_if #(.ADDR_W(AW)) mem_if ();

  im_boot_loader #(.ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .src_base (src_base),
    .dst_base (dst_base),
    .len      (len),
    .exp_sum  (exp_sum),
    .mem      (mem_if.master),
    .busy     (busy),
    .done     (done),
    .cpu_hold (cpu_hold),
    .csum     (csum),
    .csum_err (csum_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Both SRAMs are clocked on the falling edge.
  always @(negedge clk) begin
    if (mem_if.src_oe) mem_if.src_do <= src_mem[mem_if.src_a];
    if (mem_if.im_web != 4'hF) begin
      wr_t e;
      im_mem[mem_if.im_a] <= mem_if.im_di;
      n_writes++;
      chk("wr_web", {28'h0, mem_if.im_web}, 32'h0);
      if (sb_q.size() == 0) begin
        chk("unexpected_write", {18'h0, mem_if.im_a}, 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        chk("wr_addr", {18'h0, mem_if.im_a}, {18'h0, e.addr});
        chk("wr_data", mem_if.im_di, e.data);
      end
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_src_oe"}, {31'h0, mem_if.src_oe}, 32'h0);
    chk({tag, "_src_a"}, {18'h0, mem_if.src_a}, 32'h0);
    chk({tag, "_im_web"}, {28'h0, mem_if.im_web}, 32'hF);
    chk({tag, "_im_a"}, {18'h0, mem_if.im_a}, 32'h0);
    chk({tag, "_im_di"}, mem_if.im_di, 32'h0);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
    chk({tag, "_done"}, {31'h0, done}, 32'h0);
    chk({tag, "_cpu_hold"}, {31'h0, cpu_hold}, 32'h1);
    chk({tag, "_csum"}, csum, 32'h0);
    chk({tag, "_csum_err"}, {31'h0, csum_err}, 32'h0);
  endtask

  task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n,
                          input logic [31:0] es, input int repulse);
    int          lat;
    int          w0;
    int          extra_done;
    bit          hold_bad;
    bit          busy_seen;
    logic [31:0] sum_exp;
    logic [AW-1:0] a;
    wr_t         e;
    sum_exp = 32'h0;
    for (int k = 0; k < n; k++) begin
      a      = s + AW'(k);
      e.addr = d + AW'(k);
      e.data = src_mem[a];
      sum_exp += e.data;
      sb_q.push_back(e);
    end
    w0       = n_writes;
    src_base = s;
    dst_base = d;
    len      = (AW+1)'(n);
    exp_sum  = es;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", {31'h0, busy}, (n != 0) ? 32'h1 : 32'h0);
    lat       = 0;
    hold_bad  = 1'b0;
    busy_seen = busy;
    while (!done && lat < 100) begin
      if (!cpu_hold) hold_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
      start = (lat == repulse);
      if (busy) busy_seen = 1'b1;
    end
    start = 1'b0;
    chk("done_seen", {31'h0, done}, 32'h1);
    chk("done_latency", lat, (n == 0) ? 32'h0 : 32'(n + 1));
    chk("hold_during_copy", {31'h0, hold_bad}, 32'h0);
    chk("busy_seen", {31'h0, busy_seen}, (n != 0) ? 32'h1 : 32'h0);
`ifdef BOOT_CHECKSUM_EN
    chk("csum_at_done", csum, sum_exp);
`endif
    @(posedge clk); #1;
    chk("done_one_cycle", {31'h0, done}, 32'h0);
    chk("busy_after", {31'h0, busy}, 32'h0);
`ifdef BOOT_CHECKSUM_EN
    chk("csum_err", {31'h0, csum_err}, (sum_exp != es) ? 32'h1 : 32'h0);
    chk("hold_after", {31'h0, cpu_hold}, (sum_exp != es) ? 32'h1 : 32'h0);
`else
    chk("csum_off", csum, 32'h0);
    chk("csum_err_off", {31'h0, csum_err}, 32'h0);
    chk("hold_after", {31'h0, cpu_hold}, 32'h0);
`endif
    extra_done = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done) extra_done++;
    end
    chk("extra_done", extra_done, 32'h0);
    chk("write_count", n_writes - w0, n);
    chk("sb_empty", sb_q.size(), 32'h0);
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      src_mem[i] = 32'h0;
      im_mem[i]  = SENTINEL;
    end
    for (int i = 0; i < 4; i++) src_mem[16'h10 + i] = 32'hA0 + i;
    for (int i = 0; i < 4; i++) src_mem[16'h20 + i] = 32'h1111_1111 * (i + 1);
    for (int i = 0; i < 8; i++) src_mem[16'h40 + i] = 32'hC0DE_0000 + i;
    for (int i = 0; i < 8; i++) src_mem[16'h80 + i] = 32'h5500_0000 + i;
    for (int i = 0; i < 3; i++) src_mem[16'h90 + i] = i + 1;

    rst           = 1'b0;
    start         = 1'b0;
    src_base      = '0;
    dst_base      = '0;
    len           = '0;
    exp_sum       = '0;
    mem_if.src_do = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic 4-word copy.
    run_copy(14'h0010, 14'h0000, 4, 32'h0000_0286, -1);
    for (int i = 0; i < 4; i++) chk("im_basic", im_mem[i], 32'hA0 + i);

    // Zero-length request.
    run_copy(14'h0010, 14'h0200, 0, 32'h0, -1);
    chk("len0_web", {28'h0, mem_if.im_web}, 32'hF);

    // Destination wraps past the top of the space.
    run_copy(14'h0020, 14'h3FFE, 4, 32'hAAAA_AAAA, -1);
    chk("wrap_3ffe", im_mem[14'h3FFE], 32'h1111_1111);
    chk("wrap_0001", im_mem[14'h0001], 32'h4444_4444);

    // Second start during a copy is ignored.
    run_copy(14'h0040, 14'h0400, 8, 32'h0, 2);

    // Reset during the third STREAM cycle: only word 0 reaches IM.
    begin
      wr_t e;
      e.addr = 14'h0100;
      e.data = src_mem[14'h0080];
      sb_q.push_back(e);
    end
    src_base = 14'h0080;
    dst_base = 14'h0100;
    len      = 15'd8;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_reset_values("abort");
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_word0", im_mem[14'h0100], 32'h5500_0000);
    chk("abort_word1", im_mem[14'h0101], SENTINEL);
    chk("abort_sb_empty", sb_q.size(), 32'h0);
    chk("abort_hold", {31'h0, cpu_hold}, 32'h1);

    // Checksum match and mismatch on words 1, 2, 3.
    run_copy(14'h0090, 14'h0800, 3, 32'd6, -1);
    run_copy(14'h0090, 14'h0810, 3, 32'd7, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
